// File: rtl/rr_bus_arbiter.sv
// N-master round-robin bus arbiter with a registered one-hot grant and binary owner index.
// Optional tenure limit when ARB_HOLD_LIMIT_EN is defined (preempts after MAX_HOLD cycles if others wait).
module rr_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 16,
  localparam int SEL_W      = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [SEL_W-1:0]       m_select,
  output logic                   bus_busy
);

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || MAX_HOLD < 2) begin : g_bad_params
      $error("rr_bus_arbiter: NUM_MASTERS must be 2..16 and MAX_HOLD >= 2");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t           state, next_state;
  logic [SEL_W-1:0] owner, next_owner;
  logic [SEL_W-1:0] last_owner, next_last_owner;
  logic [NUM_MASTERS-1:0] owner_onehot;
  logic [NUM_MASTERS-1:0] other_req;

  // First set bit of r, searching upward from last+1 with wrap-around.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      if (!found && r[idx]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign owner_onehot = NUM_MASTERS'(1) << owner;
  assign other_req    = req & ~owner_onehot;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt, next_hold_cnt;
  logic              hold_expired;

  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  logic hold_expired;

  assign hold_expired = 1'b0;
`endif

  always_comb begin
    next_state      = state;
    next_owner      = owner;
    next_last_owner = last_owner;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          next_state      = ST_OWNED;
          next_owner      = rr_pick(req, last_owner);
          next_last_owner = next_owner;
        end
      end
      ST_OWNED: begin
        // A release or an expired tenure both hand off to the next waiting master.
        if (!req[owner] || hold_expired) begin
          if (|other_req) begin
            next_owner      = rr_pick(other_req, owner);
            next_last_owner = next_owner;
          end else if (!req[owner]) begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_comb begin
    next_hold_cnt = '0;
    if (state == ST_OWNED && next_state == ST_OWNED && next_owner == owner) begin
      next_hold_cnt = hold_expired ? hold_cnt : hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= next_hold_cnt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= SEL_W'(NUM_MASTERS - 1);
      grant      <= '0;
      m_select   <= '0;
      bus_busy   <= 1'b0;
    end else begin
      state      <= next_state;
      owner      <= next_owner;
      last_owner <= next_last_owner;
      if (next_state == ST_OWNED) begin
        grant    <= NUM_MASTERS'(1) << next_owner;
        m_select <= next_owner;
        bus_busy <= 1'b1;
      end else begin
        grant    <= '0;
        m_select <= '0;
        bus_busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Parametrised N-master round-robin bus arbiter. It replaces the fixed two-master arbiter in the system bus and sits between the master request lines and the bus address/data multiplexers. It issues a registered one-hot grant plus a binary master-select index that steers the bus muxes. Fairness is rotating priority, and an optional hold limit bounds how long any single master can own the bus.

## Interface
- NUM_MASTERS, default 4: number of requesting masters; legal range 2..16.
- MAX_HOLD, default 16: maximum tenure in cycles while other requests pend; legal range ≥2; used only with ARB_HOLD_LIMIT_EN.
- SEL_W, default $clog2(NUM_MASTERS): width of m_select; derived, never overridden.
- clk  input  1  bus clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NUM_MASTERS  per-master bus request; bit i = master i.
- grant  output  NUM_MASTERS  registered grant, one-hot or all-zero.
- m_select  output  SEL_W  binary index of current owner; 0 when no grant.
- bus_busy  output  1  high whenever any grant bit is high.

## Operation
- State machine with two states.
  - IDLE: no owner.
  - OWNED: one owner; the owner index is held in a register.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, grant=0, m_select=0, bus_busy=0, hold counter=0.
  - last_owner=NUM_MASTERS-1, so master 0 has top priority after reset.
- Round-robin pick: the first set bit of req, searching from (last_owner+1) mod N upward with wrap-around.
- IDLE:
  - If req≠0, go to OWNED with the picked master as owner. Set grant=onehot(owner), m_select=owner, and update last_owner.
  - Otherwise stay in IDLE with all outputs at 0.
- OWNED, with req[owner]=1: hold the grant. All other req changes are ignored.
- OWNED, with req[owner]=0:
  - If any other req bit is set, hand off directly to the next round-robin pick, which excludes the current owner. There is no idle cycle between owners.
  - Otherwise return to IDLE: grant=0, m_select=0. last_owner keeps the departing owner.
- Simultaneous events: if the owner drops req in the same cycle that others raise req, the handoff rule applies, using req as sampled at that edge.
- Invariants:
  - grant is never multi-hot.
  - m_select always equals the index of the set grant bit, or 0 when grant=0.
  - bus_busy = |grant.
- Reset mid-tenure: at the next edge, all outputs clear and round-robin priority restarts at master 0.
- Requests from masters that are not granted may be withdrawn at any time without effect.

## Timing
- Request-to-grant latency:
  - Sampled req at edge k; grant visible after edge k.
  - When idle, this is a 1-cycle latency.
- Release latency:
  - The owner deasserts req before edge k; its grant drops after edge k.
  - The owner therefore sees grant for exactly one cycle after its req falls.
- Handoff: the old grant bit falls and the new one rises on the same edge.
- All outputs are registered; there is no combinational path from req to grant.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - A hold counter clears on every grant change and increments each cycle in OWNED. Its width is $clog2(MAX_HOLD+1), and it saturates at MAX_HOLD-1.
  - Preemption occurs when the counter equals MAX_HOLD-1 and any non-owner req is set. At the next edge the grant moves to the round-robin pick and the counter clears, even if req[owner]=1.
  - A preempted master that keeps req asserted re-enters round-robin as an ordinary requester.
  - With no competing request, the owner keeps the bus indefinitely.
- ARB_HOLD_LIMIT_EN undefined:
  - No counter is built and MAX_HOLD is ignored.
  - The owner holds the bus until it drops req.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 → grant=0, m_select=0, bus_busy=0 throughout. After release, the first grant goes to master 0 one cycle later.
- Single request: req=4'b0100 from IDLE → grant=4'b0100 and m_select=2 after 1 edge. Dropping req → grant=0 one edge later.
- Rotation:
  - Stimulus: req=4'b1111 held; each owner drops its req for 1 cycle after 3 cycles of tenure, then re-raises it.
  - Required grant order: 0,1,2,3,0. No idle cycle at handoffs; never more than one grant bit set.
- Wrap priority: owner 3 releases while req=4'b0011 → grant goes to master 0, not master 1.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=4): master 1 holds req, and master 2 raises req while master 1 is granted → grant moves to master 2 after master 1's fourth granted cycle. Repeating with master 2 idle → master 1 is never preempted.
- Mid-tenure reset: master 2 owns the bus and rst_n=0 for 1 cycle → all outputs are 0 at the next edge. With req=4'b0110, the next grant goes to master 1.
